// File: rtl/cam_capture.sv
// Camera parallel-bus capture: synchronises VSYNC/HREF, frames the byte stream into
// pixels with start-of-frame / end-of-line markers, and measures line and frame geometry.
module cam_capture #(
   parameter int BYTES_PER_PIX = 1,
   parameter int PIX_PER_LINE  = 640,
   parameter int NUM_LINES     = 480
) (
   input  logic                       pclk,
   input  logic                       rst_n,
   input  logic [7:0]                 din,
   input  logic                       vsync,
   input  logic                       href,
   input  logic                       start,
   input  logic                       stop,
   output logic [8*BYTES_PER_PIX-1:0] pixel,
   output logic                       pixel_valid,
   output logic                       sof,
   output logic                       eol,
   output logic                       busy,
   output logic                       line_err,
   output logic [15:0]                hlen,
   output logic [15:0]                vlen,
   output logic [15:0]                frame_cnt
);

   localparam int          PW         = 8 * BYTES_PER_PIX;
   localparam logic [15:0] LINE_BYTES = 16'(PIX_PER_LINE * BYTES_PER_PIX);
   localparam logic [15:0] LINES_NOM  = 16'(NUM_LINES);
   localparam logic [15:0] BPP16      = 16'(BYTES_PER_PIX);
   localparam logic [1:0]  LAST_PHASE = 2'(BYTES_PER_PIX - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      HBLANK,
      ACTIVE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [2:0]    vs_sr;
   logic [4:0]    hr_sr;
   logic [7:0]    din_s0;
   logic [7:0]    din_s1;
   logic [7:0]    din_s2;
   logic [7:0]    byte_q;
   logic          sync_vs;
   logic          sync_vs_d;
   logic          vs_rise;
   logic          line_go;
   logic          href_al;
   logic          href_fall;

   logic [15:0]   byte_cnt;
   logic [15:0]   line_cnt;
   logic [15:0]   hr_cnt;
   logic [1:0]    phase;
   logic [PW-1:0] acc;
   logic [PW-1:0] acc_nxt;
   logic          sof_pending;
   logic          stop_pending;

   logic          frame_start;
   logic          frame_end;
   logic          load_cnt;
   logic          take_byte;
   logic          short_line;
   logic          last_byte;

   // Input pipeline; hr_sr[3] is HREF aligned with byte_q, hr_sr[4] its previous value.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_sr     <= '0;
         hr_sr     <= '0;
         din_s0    <= '0;
         din_s1    <= '0;
         din_s2    <= '0;
         byte_q    <= '0;
         sync_vs_d <= 1'b0;
      end else begin
         vs_sr     <= {vs_sr[1:0], vsync};
         hr_sr     <= {hr_sr[3:0], href};
         din_s0    <= din;
         din_s1    <= din_s0;
         din_s2    <= din_s1;
         byte_q    <= din_s2;
         sync_vs_d <= sync_vs;
      end
   end

   assign sync_vs   = &vs_sr;
   assign vs_rise   = sync_vs & ~sync_vs_d;
   assign line_go   = (hr_sr[2:0] == 3'b111) & ~hr_sr[3] & ~sync_vs;
   assign href_al   = hr_sr[3];
   assign href_fall = hr_sr[4] & ~hr_sr[3];
   assign last_byte = (byte_cnt == 16'd1);
   assign acc_nxt   = PW'({acc, byte_q});
   assign busy      = (state != IDLE);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Frame end is only recognised between lines; a frame restart stays in HBLANK.
   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      load_cnt    = 1'b0;
      take_byte   = 1'b0;
      short_line  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (sync_vs) begin
               state_nxt   = HBLANK;
               frame_start = 1'b1;
            end
         end
         HBLANK: begin
            if (vs_rise) begin
               frame_end = 1'b1;
               if (stop_pending || stop) begin
                  state_nxt = IDLE;
               end else begin
                  frame_start = 1'b1;
               end
            end else if (line_go) begin
               state_nxt = ACTIVE;
               load_cnt  = 1'b1;
            end
         end
         ACTIVE: begin
            if (!href_al) begin
               short_line = 1'b1;
               state_nxt  = HBLANK;
            end else begin
               take_byte = 1'b1;
               if (last_byte) begin
                  state_nxt = HBLANK;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Control flags and frame-level counters.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         stop_pending <= 1'b0;
         sof_pending  <= 1'b0;
         line_err     <= 1'b0;
         line_cnt     <= '0;
         vlen         <= '0;
         frame_cnt    <= '0;
      end else begin
         if (busy && stop) begin
            stop_pending <= 1'b1;
         end else if (start) begin
            stop_pending <= 1'b0;
         end
         if (state_nxt == IDLE) begin
            stop_pending <= 1'b0;
         end

         if (start) begin
            line_err <= 1'b0;
         end else if (short_line) begin
            line_err <= 1'b1;
         end

         if (start && !busy) begin
            frame_cnt <= '0;
         end

         if (frame_end) begin
            vlen <= line_cnt;
            if (line_cnt == LINES_NOM) begin
               frame_cnt <= frame_cnt + 16'd1;
            end
         end

         if (frame_start) begin
            line_cnt    <= '0;
            sof_pending <= 1'b1;
         end else if (take_byte && phase == LAST_PHASE) begin
            sof_pending <= 1'b0;
            if (last_byte && line_cnt != 16'hFFFF) begin
               line_cnt <= line_cnt + 16'd1;
            end
         end
      end
   end

   // Byte-to-pixel assembly; first byte received ends up in the most significant position.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt    <= '0;
         phase       <= '0;
         acc         <= '0;
         pixel       <= '0;
         pixel_valid <= 1'b0;
         sof         <= 1'b0;
         eol         <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         sof         <= 1'b0;
         eol         <= 1'b0;
         if (load_cnt) begin
            byte_cnt <= LINE_BYTES;
            phase    <= '0;
         end else if (short_line) begin
            phase <= '0;
         end else if (take_byte) begin
            byte_cnt <= byte_cnt - 16'd1;
            if (phase == LAST_PHASE) begin
               pixel       <= acc_nxt;
               pixel_valid <= 1'b1;
               sof         <= sof_pending;
               eol         <= last_byte;
               phase       <= '0;
            end else begin
               acc   <= acc_nxt;
               phase <= phase + 2'd1;
            end
         end
      end
   end

   // HREF period measurement runs on the aligned HREF, independent of the FSM.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         hr_cnt <= '0;
         hlen   <= '0;
      end else begin
         if (href_al) begin
            if (hr_cnt != 16'hFFFF) begin
               hr_cnt <= hr_cnt + 16'd1;
            end
         end else begin
            hr_cnt <= '0;
            if (href_fall && busy) begin
               hlen <= hr_cnt / BPP16;
            end
         end
      end
   end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: an RGB565 instance (4 pix/line, 2 lines) and a raw
// 8-bit instance share the same camera bus; pixel events are logged on the falling edge.
module tb_cam_capture;

   logic       pclk  = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din   = '0;
   logic       vsync = 1'b0;
   logic       href  = 1'b0;
   logic       start = 1'b0;
   logic       stop  = 1'b0;

   logic [15:0] pix2;
   logic        pv2, sof2, eol2, busy2, lerr2;
   logic [15:0] hlen2, vlen2, fcnt2;
   logic [7:0]  pix1;
   logic        pv1, sof1, eol1, busy1, lerr1;
   logic [15:0] hlen1, vlen1, fcnt1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int line_c   = 0;

   logic [15:0] pix2_q[$];
   bit          sof2_q[$];
   bit          eol2_q[$];
   int          cyc2_q[$];
   logic [7:0]  pix1_q[$];
   bit          sof1_q[$];
   bit          eol1_q[$];
   int          cyc1_q[$];

   cam_capture #(.BYTES_PER_PIX(2), .PIX_PER_LINE(4), .NUM_LINES(2)) dut (
      .pclk(pclk), .rst_n(rst_n), .din(din), .vsync(vsync), .href(href),
      .start(start), .stop(stop), .pixel(pix2), .pixel_valid(pv2), .sof(sof2),
      .eol(eol2), .busy(busy2), .line_err(lerr2), .hlen(hlen2), .vlen(vlen2),
      .frame_cnt(fcnt2)
   );

   cam_capture #(.BYTES_PER_PIX(1), .PIX_PER_LINE(4), .NUM_LINES(2)) dut1 (
      .pclk(pclk), .rst_n(rst_n), .din(din), .vsync(vsync), .href(href),
      .start(start), .stop(stop), .pixel(pix1), .pixel_valid(pv1), .sof(sof1),
      .eol(eol1), .busy(busy1), .line_err(lerr1), .hlen(hlen1), .vlen(vlen1),
      .frame_cnt(fcnt1)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc++;

   always @(negedge pclk) begin
      if (pv2) begin
         pix2_q.push_back(pix2);
         sof2_q.push_back(sof2);
         eol2_q.push_back(eol2);
         cyc2_q.push_back(cyc);
      end
      if (pv1) begin
         pix1_q.push_back(pix1);
         sof1_q.push_back(sof1);
         eol1_q.push_back(eol1);
         cyc1_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Holds one set of bus values across exactly one sampling edge.
   task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d,
                                input logic st, input logic sp);
      vsync = vs;
      href  = hr;
      din   = d;
      start = st;
      stop  = sp;
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send_line(input logic [7:0] first, input logic [7:0] step, input int n,
                            input int stop_at);
      line_c = cyc;
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, 8'(first + i * step), 1'b0, i == stop_at);
      end
      idle(8);
   endtask

   task automatic send_vsync(input int n);
      repeat (n) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(6);
   endtask

   task automatic pulse_start();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      idle(2);
   endtask

   task automatic clear_logs();
      pix2_q.delete(); sof2_q.delete(); eol2_q.delete(); cyc2_q.delete();
      pix1_q.delete(); sof1_q.delete(); eol1_q.delete(); cyc1_q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      clear_logs();
   endtask

   initial begin
      logic [15:0] exp_pix[4];
      logic [7:0]  exp_raw[4];
      int          first_c;
      exp_pix = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
      exp_raw = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

      // Reset values while rst_n is held low
      idle(3);
      checkOutput("rst pixel_valid", pv2, 0);
      checkOutput("rst busy", busy2, 0);
      checkOutput("rst pixel", pix2, 0);
      checkOutput("rst line_err", lerr2, 0);
      checkOutput("rst hlen", hlen2, 0);
      checkOutput("rst vlen", vlen2, 0);
      checkOutput("rst frame_cnt", fcnt2, 0);
      checkOutput("rst busy raw", busy1, 0);
      rst_n = 1'b1;
      idle(2);
      checkOutput("idle busy", busy2, 0);

      // Nominal RGB565 frame: two full lines then frame end
      do_reset();
      pulse_start();
      checkOutput("B busy after start", busy2, 1);
      send_vsync(3);
      send_line(8'h01, 8'h01, 8, -1);
      first_c = line_c;
      send_line(8'h01, 8'h01, 8, -1);
      checkOutput("B pixel count", pix2_q.size(), 8);
      for (int i = 0; i < 8 && i < pix2_q.size(); i++) begin
         checkOutput($sformatf("B pix%0d", i), pix2_q[i], exp_pix[i % 4]);
         checkOutput($sformatf("B sof%0d", i), sof2_q[i], i == 0);
         checkOutput($sformatf("B eol%0d", i), eol2_q[i], i % 4 == 3);
      end
      if (cyc2_q.size() > 0) checkOutput("B latency", cyc2_q[0] - first_c, 6);
      checkOutput("B hlen", hlen2, 4);
      send_vsync(3);
      checkOutput("B vlen", vlen2, 2);
      checkOutput("B frame_cnt", fcnt2, 1);
      checkOutput("B line_err", lerr2, 0);
      checkOutput("B busy", busy2, 1);

      // Raw 8-bit instance: one pixel per byte
      do_reset();
      pulse_start();
      send_vsync(3);
      send_line(8'hAA, 8'h11, 4, -1);
      checkOutput("C pixel count", pix1_q.size(), 4);
      for (int i = 0; i < 4 && i < pix1_q.size(); i++) begin
         checkOutput($sformatf("C pix%0d", i), pix1_q[i], exp_raw[i]);
         checkOutput($sformatf("C eol%0d", i), eol1_q[i], i == 3);
         checkOutput($sformatf("C cycle%0d", i), cyc1_q[i] - line_c, 5 + i);
      end
      if (sof1_q.size() > 0) checkOutput("C sof0", sof1_q[0], 1);
      checkOutput("C hlen", hlen1, 4);
      checkOutput("C line_err", lerr1, 0);

      // Short line: partial pixel dropped, sticky error, frame not counted
      do_reset();
      pulse_start();
      send_vsync(3);
      send_line(8'h01, 8'h01, 8, -1);
      checkOutput("D line_err clean", lerr2, 0);
      send_line(8'h01, 8'h01, 5, -1);
      checkOutput("D pixel count", pix2_q.size(), 6);
      if (pix2_q.size() >= 6) begin
         checkOutput("D pix4", pix2_q[4], 16'h0102);
         checkOutput("D pix5", pix2_q[5], 16'h0304);
         checkOutput("D eol4", eol2_q[4], 0);
         checkOutput("D eol5", eol2_q[5], 0);
      end
      checkOutput("D line_err", lerr2, 1);
      checkOutput("D hlen", hlen2, 2);
      send_vsync(3);
      checkOutput("D vlen", vlen2, 1);
      checkOutput("D frame_cnt", fcnt2, 0);
      checkOutput("D line_err sticky", lerr2, 1);

      // Short VSYNC / HREF glitches must be filtered
      do_reset();
      pulse_start();
      send_vsync(2);
      checkOutput("E busy armed", busy2, 1);
      send_line(8'h01, 8'h01, 8, -1);
      checkOutput("E no pixels while armed", pix2_q.size(), 0);
      send_vsync(3);
      applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
      idle(8);
      checkOutput("E href glitch", pix2_q.size(), 0);
      send_line(8'h01, 8'h01, 8, -1);
      checkOutput("E line after glitch", pix2_q.size(), 4);
      send_vsync(2);
      checkOutput("E vsync glitch vlen", vlen2, 0);
      checkOutput("E vsync glitch frame_cnt", fcnt2, 0);
      send_vsync(3);
      checkOutput("E real vsync vlen", vlen2, 1);

      // Stop mid-line: frame completes, block idles at the next frame boundary
      do_reset();
      pulse_start();
      send_vsync(3);
      send_line(8'h01, 8'h01, 8, -1);
      send_line(8'h01, 8'h01, 8, 3);
      checkOutput("F busy after stop", busy2, 1);
      checkOutput("F pixel count", pix2_q.size(), 8);
      send_vsync(3);
      checkOutput("F busy at frame end", busy2, 0);
      checkOutput("F frame_cnt", fcnt2, 1);
      checkOutput("F vlen", vlen2, 2);
      send_line(8'h01, 8'h01, 8, -1);
      checkOutput("F no pixels after stop", pix2_q.size(), 8);

      // Asynchronous reset in the middle of an active line
      do_reset();
      pulse_start();
      send_vsync(3);
      send_line(8'h01, 8'h01, 8, -1);
      send_line(8'h01, 8'h01, 8, -1);
      send_vsync(3);
      checkOutput("G frame_cnt before", fcnt2, 1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b0);
      end
      checkOutput("G pixel_valid before", pv2, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("G pixel_valid", pv2, 0);
      checkOutput("G busy", busy2, 0);
      checkOutput("G hlen", hlen2, 0);
      checkOutput("G vlen", vlen2, 0);
      checkOutput("G frame_cnt", fcnt2, 0);
      idle(3);
      rst_n = 1'b1;
      idle(2);
      send_line(8'h01, 8'h01, 8, -1);
      checkOutput("G no pixels after reset", pix2_q.size(), 8);
      checkOutput("G busy after release", busy2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter BYTES_PER_PIX, 1, bytes per pixel on bus: 1 = raw, 2 = RGB565, first byte is MSB; other values illegal.
REQ-002 Parameter PIX_PER_LINE, 640, nominal pixels per line, 1..4095.
REQ-003 Parameter NUM_LINES, 480, nominal lines per frame, 1..4095.
REQ-004 pclk  in  1  camera pixel clock; sole clock.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 din  in  8  camera data D7..D0.
REQ-007 vsync  in  1  camera VSYNC, active-high.
REQ-008 href  in  1  camera HREF, active-high.
REQ-009 start  in  1  one-cycle pulse; arms capture.
REQ-010 stop  in  1  one-cycle pulse; ends capture at the next frame boundary.
REQ-011 pixel  out  8*BYTES_PER_PIX  assembled pixel, registered.
REQ-012 pixel_valid  out  1  pixel holds a new pixel this cycle.
REQ-013 sof  out  1  with pixel_valid: first pixel of frame.
REQ-014 eol  out  1  with pixel_valid: last pixel of line.
REQ-015 busy  out  1  state is not IDLE.
REQ-016 line_err  out  1  sticky: a line was shorter than nominal.
REQ-017 hlen  out  16  pixel count of the most recent completed href-high period.
REQ-018 vlen  out  16  line count of the most recent completed frame.
REQ-019 frame_cnt  out  16  number of frames fully delivered since start.

Function
REQ-020 din, href and vsync SHALL pass through a 3-stage register pipeline: sync_vs = vsync high on 3 consecutive samples; line_go = href high on 3 consecutive samples, 4th-oldest sample low, and sync_vs low.
REQ-021 The first byte of a line SHALL appear at the byte stage in the cycle after line_go; the delayed href SHALL stay aligned with the byte stream.
REQ-022 FSM states SHALL be IDLE, ARMED, HBLANK and ACTIVE.
REQ-023 IDLE -> ARMED on start.
REQ-024 ARMED -> HBLANK on sync_vs; this clears the line counter and sets sof_pending.
REQ-025 HBLANK -> ACTIVE on line_go; the byte counter loads PIX_PER_LINE*BYTES_PER_PIX.
REQ-026 In ACTIVE, decrement the byte counter every cycle; at count 1, go to HBLANK.
REQ-027 In ACTIVE, if aligned href is low for any byte: set line_err, go to HBLANK, drop any partial pixel, assert no eol.
REQ-028 Byte assembly: every BYTES_PER_PIX-th byte in ACTIVE SHALL assert pixel_valid for 1 cycle, with pixel = {byte0,...,byteN-1}; BYTES_PER_PIX=1 gives pixel_valid every ACTIVE cycle.
REQ-029 Latency: pixel_valid SHALL rise BYTES_PER_PIX cycles after entering ACTIVE.
REQ-030 sof SHALL accompany the first pixel_valid after sof_pending is set, then clear sof_pending.
REQ-031 eol SHALL accompany the pixel_valid of the final counted byte.
REQ-032 In HBLANK, sync_vs rising edge (frame end) SHALL:
- latch vlen from the line counter;
- increment frame_cnt (wrapping 16 bit) if line counter = NUM_LINES;
- go to IDLE if stop_pending, else restart the frame as in REQ-024.
REQ-033 stop sets stop_pending.
- In ARMED, stop SHALL go to IDLE immediately.
- In IDLE, stop is ignored.
- start clears stop_pending; start in a non-IDLE state is otherwise ignored.
REQ-034 Line counter SHALL increment per eol and saturate at 16'hFFFF.
REQ-035 hlen SHALL latch on each falling edge of aligned href while not IDLE, as pixels seen in that period (bytes/BYTES_PER_PIX, truncated); it latches whether long, short or nominal.
REQ-036 line_err SHALL clear only on start or reset.
REQ-037 If line_go and sync_vs coincide, sync_vs SHALL take priority.

Reset
REQ-038 While rst_n is low:
- state = IDLE;
- all counters, pending flags and outputs = 0;
- pixel = 0.
REQ-039 Reset asserted mid-line SHALL abort immediately with no further pixel_valid; after release, the block waits for start.

Verification (BYTES_PER_PIX=2, PIX_PER_LINE=4, NUM_LINES=2 unless noted)
REQ-040 Stimulus: start; vsync for 3 cycles; 2 lines of 8 bytes 01..08 -> 4 pixel_valid per line: 0x0102, 0x0304, 0x0506, 0x0708. sof on the first; eol on 0x0708. Next vsync -> vlen=2, frame_cnt=1.
REQ-041 Stimulus: BYTES_PER_PIX=1, line of 4 bytes AA,BB,CC,DD -> pixel_valid on 4 consecutive cycles, starting 1 cycle after ACTIVE entry. hlen=4.
REQ-042 Stimulus: href drops after 5 bytes -> pixels 0x0102, 0x0304 only; no eol; line_err=1; hlen=2. Frame end -> frame_cnt not incremented.
REQ-043 Stimulus: 2-cycle href glitch; 2-cycle vsync glitch -> no state change, no pixel_valid.
REQ-044 Stimulus: stop mid-line of frame 1 -> frame 1 completes; at the following vsync busy=0 and frame_cnt=1. A later line produces no pixel_valid.
REQ-045 Stimulus: rst_n low mid-ACTIVE -> pixel_valid, busy, hlen, vlen, frame_cnt = 0 immediately (asynchronous).
